// File: rtl/pattern_seq_detector.sv
// pattern_seq_detector
// Serial bit-pattern detector with a runtime-programmable PAT_W-bit target.
// Accepts a bit only when en=1. Supports overlapping and non-overlapping
// match modes and a synchronous flush of the history. A saturating counter
// tallies matches. The match pulse y is combinational (Mealy): it is valid
// in the same cycle as the completing bit. match_count and cnt_sat follow
// one edge later.

module pattern_seq_detector #(
  parameter int PAT_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic             a,
  input  logic             en,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  // fill runs 0..PAT_W-1, so $clog2(PAT_W) bits are enough (PAT_W >= 2).
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [PAT_W-2:0]  HIST_ZERO = {(PAT_W-1){1'b0}};

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [PAT_W-1:0]  window_s;
  logic              match_s;

  // The candidate window is the stored history plus the bit on the wire.
  // Its low PAT_W-1 bits are also the shifted history for the next cycle.
  assign window_s = {hist_q, a};

  // Mealy match: a full window of accepted bits that equals the pattern.
  always_comb begin
    match_s = 1'b0;
    if (en && !flush && (fill_q == FILL_MAX) && (window_s == pattern)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // History and fill tracking. Flush wins over en. A non-overlapping match
  // empties fill so that none of the matched bits can start the next match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = HIST_ZERO;
      fill_d = FILL_ZERO;
    end else if (en) begin
      hist_d = window_s[PAT_W-2:0];
      if (match_s && !overlap) begin
        fill_d = FILL_ZERO;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // Saturating match counter. A clear in the same cycle as a match still
  // counts that match, so the counter lands on 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      if (match_s) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (match_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers. Reset discards any partial history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= HIST_ZERO;
      fill_q <= FILL_ZERO;
      cnt_q  <= CNT_ZERO;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output drive: y stays combinational, and cnt_sat decodes the counter.
  always_comb begin
    y           = match_s;
    match_count = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_sat = 1'b1;
    end else begin
      cnt_sat = 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed testbench for pattern_seq_detector. Three instances share the
// clock and control inputs:
//   dut2 - PAT_W=2, CNT_W=8
//   dut4 - PAT_W=4, CNT_W=8
//   dutc - PAT_W=2, CNT_W=2 (used for the saturation case)

module tb_pattern_seq_detector;

  logic       clk;
  logic       reset_n;
  logic       a;
  logic       en;
  logic       overlap;
  logic       flush;
  logic       clr_cnt;
  logic [1:0] pat2;
  logic [3:0] pat4;
  logic [1:0] patc;

  logic       y2, y4, yc;
  logic [7:0] cnt2, cnt4;
  logic [1:0] cntc;
  logic       sat2, sat4, satc;

  int checks;
  int failures;

  pattern_seq_detector #(.PAT_W(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset_n), .a(a), .en(en), .pattern(pat2),
    .overlap(overlap), .flush(flush), .clr_cnt(clr_cnt),
    .y(y2), .match_count(cnt2), .cnt_sat(sat2)
  );

  pattern_seq_detector #(.PAT_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset_n), .a(a), .en(en), .pattern(pat4),
    .overlap(overlap), .flush(flush), .clr_cnt(clr_cnt),
    .y(y4), .match_count(cnt4), .cnt_sat(sat4)
  );

  pattern_seq_detector #(.PAT_W(2), .CNT_W(2)) dutc (
    .clk(clk), .reset(reset_n), .a(a), .en(en), .pattern(patc),
    .overlap(overlap), .flush(flush), .clr_cnt(clr_cnt),
    .y(yc), .match_count(cntc), .cnt_sat(satc)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one bit and wait until the negative edge, where y is sampled.
  task automatic apply(input logic a_v, input logic en_v);
    a  = a_v;
    en = en_v;
    @(negedge clk);
  endtask

  // Let the rising edge consume the bit, then settle before sampling registers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of flush plus counter clear to start from a known state.
  task automatic clean();
    a       = 1'b0;
    en      = 1'b0;
    flush   = 1'b1;
    clr_cnt = 1'b1;
    tick();
    flush   = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    a = 1'b1; en = 1'b1;
    pat2 = 2'b11; pat4 = 4'b1111; patc = 2'b11;
    @(negedge clk);
    checks++;
    if ({y2, y4, yc} !== 3'b000) begin
      failures++;
      $display("FAIL reset_y: got %b expected 000", {y2, y4, yc});
    end
    checks++;
    if (cnt4 !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt4);
    end
    checks++;
    if ({sat2, sat4, satc} !== 3'b000) begin
      failures++;
      $display("FAIL reset_sat: got %b expected 000", {sat2, sat4, satc});
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_pat2_overlap();
    logic [5:0] stream_v;
    logic [5:0] expy_v;
    stream_v = 6'b001101;
    expy_v   = 6'b001001;
    pat2 = 2'b01;
    overlap = 1'b1;
    clean();
    for (int i = 0; i < 6; i++) begin
      apply(stream_v[5-i], 1'b1);
      checks++;
      if (y2 !== expy_v[5-i]) begin
        failures++;
        $display("FAIL pat2_y bit%0d: got %b expected %b", i + 1, y2, expy_v[5-i]);
      end
      tick();
    end
    checks++;
    if (cnt2 !== 8'd2) begin
      failures++;
      $display("FAIL pat2_cnt: got %0d expected 2", cnt2);
    end
  endtask

  task automatic test_pat4_modes();
    logic [6:0] stream_v;
    logic [6:0] expy_v;
    logic [7:0] expc_v;
    stream_v = 7'b0101010;
    pat4 = 4'b0101;
    for (int m = 0; m < 2; m++) begin
      overlap = (m == 0) ? 1'b1 : 1'b0;
      expy_v  = (m == 0) ? 7'b0001010 : 7'b0001000;
      expc_v  = (m == 0) ? 8'd2 : 8'd1;
      clean();
      for (int i = 0; i < 7; i++) begin
        apply(stream_v[6-i], 1'b1);
        checks++;
        if (y4 !== expy_v[6-i]) begin
          failures++;
          $display("FAIL pat4_y ovl=%0d bit%0d: got %b expected %b",
                   overlap, i + 1, y4, expy_v[6-i]);
        end
        tick();
      end
      checks++;
      if (cnt4 !== expc_v) begin
        failures++;
        $display("FAIL pat4_cnt ovl=%0d: got %0d expected %0d", overlap, cnt4, expc_v);
      end
    end
  endtask

  task automatic test_gap();
    logic [2:0] gap_v;
    pat4 = 4'b0101;
    overlap = 1'b1;
    gap_v = 3'b101;
    clean();
    apply(1'b0, 1'b1); tick();
    apply(1'b1, 1'b1); tick();
    apply(1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      apply(gap_v[2-i], 1'b0);
      checks++;
      if (y4 !== 1'b0) begin
        failures++;
        $display("FAIL gap_y cycle%0d: got %b expected 0", i, y4);
      end
      tick();
    end
    apply(1'b1, 1'b1);
    checks++;
    if (y4 !== 1'b1) begin
      failures++;
      $display("FAIL gap_join_y: got %b expected 1", y4);
    end
    tick();
    checks++;
    if (cnt4 !== 8'd1) begin
      failures++;
      $display("FAIL gap_cnt: got %0d expected 1", cnt4);
    end
  endtask

  task automatic test_saturation();
    logic [5:0] expy_v;
    int exp_cnt [6];
    logic [5:0] exp_sat;
    expy_v  = 6'b011111;
    exp_cnt = '{0, 1, 2, 3, 3, 3};
    exp_sat = 6'b000111;
    patc = 2'b11;
    overlap = 1'b1;
    clean();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1);
      checks++;
      if (yc !== expy_v[5-i]) begin
        failures++;
        $display("FAIL sat_y bit%0d: got %b expected %b", i + 1, yc, expy_v[5-i]);
      end
      tick();
      checks++;
      if (cntc !== exp_cnt[i][1:0]) begin
        failures++;
        $display("FAIL sat_cnt bit%0d: got %0d expected %0d", i + 1, cntc, exp_cnt[i]);
      end
      checks++;
      if (satc !== exp_sat[5-i]) begin
        failures++;
        $display("FAIL sat_flag bit%0d: got %b expected %b", i + 1, satc, exp_sat[5-i]);
      end
    end
    clr_cnt = 1'b1;
    apply(1'b1, 1'b1);
    checks++;
    if (yc !== 1'b1) begin
      failures++;
      $display("FAIL clr_match_y: got %b expected 1", yc);
    end
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (cntc !== 2'd1) begin
      failures++;
      $display("FAIL clr_match_cnt: got %0d expected 1", cntc);
    end
    checks++;
    if (satc !== 1'b0) begin
      failures++;
      $display("FAIL clr_match_sat: got %b expected 0", satc);
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] quad_v;
    logic [3:0] expy_v;
    quad_v = 4'b0101;
    expy_v = 4'b0001;
    pat4 = 4'b0101;
    overlap = 1'b0;
    clean();
    for (int i = 0; i < 4; i++) begin
      apply(quad_v[3-i], 1'b1); tick();
    end
    apply(1'b0, 1'b1); tick();
    apply(1'b1, 1'b1); tick();
    apply(1'b0, 1'b1); tick();
    checks++;
    if (cnt4 !== 8'd1) begin
      failures++;
      $display("FAIL rst_pre_cnt: got %0d expected 1", cnt4);
    end
    en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cnt4 !== 8'd0) begin
      failures++;
      $display("FAIL rst_async_cnt: got %0d expected 0", cnt4);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(1'b1, 1'b1);
    checks++;
    if (y4 !== 1'b0) begin
      failures++;
      $display("FAIL rst_straddle_y: got %b expected 0", y4);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(quad_v[3-i], 1'b1);
      checks++;
      if (y4 !== expy_v[3-i]) begin
        failures++;
        $display("FAIL rst_after_y bit%0d: got %b expected %b", i + 1, y4, expy_v[3-i]);
      end
      tick();
    end
    checks++;
    if (cnt4 !== 8'd1) begin
      failures++;
      $display("FAIL rst_after_cnt: got %0d expected 1", cnt4);
    end
  endtask

  task automatic test_flush();
    logic [3:0] quad_v;
    logic [3:0] expy_v;
    quad_v = 4'b0101;
    expy_v = 4'b0001;
    pat4 = 4'b0101;
    overlap = 1'b0;
    clean();
    apply(1'b0, 1'b1); tick();
    apply(1'b1, 1'b1); tick();
    apply(1'b0, 1'b1); tick();
    flush = 1'b1;
    apply(1'b1, 1'b1);
    checks++;
    if (y4 !== 1'b0) begin
      failures++;
      $display("FAIL flush_y: got %b expected 0", y4);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (cnt4 !== 8'd0) begin
      failures++;
      $display("FAIL flush_cnt: got %0d expected 0", cnt4);
    end
    for (int i = 0; i < 4; i++) begin
      apply(quad_v[3-i], 1'b1);
      checks++;
      if (y4 !== expy_v[3-i]) begin
        failures++;
        $display("FAIL flush_after_y bit%0d: got %b expected %b", i + 1, y4, expy_v[3-i]);
      end
      tick();
    end
    checks++;
    if (cnt4 !== 8'd1) begin
      failures++;
      $display("FAIL flush_after_cnt: got %0d expected 1", cnt4);
    end
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    a        = 1'b0;
    en       = 1'b0;
    overlap  = 1'b1;
    flush    = 1'b0;
    clr_cnt  = 1'b0;
    pat2     = 2'b00;
    pat4     = 4'b0000;
    patc     = 2'b00;
    #12;
    test_reset();
    test_pat2_overlap();
    test_pat4_modes();
    test_gap();
    test_saturation();
    test_reset_midstream();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
